// File: rtl/instr_queue_param.sv
// ---------------------------------------------------------------------------
// instr_queue_param
//
// Purpose:
//   Circular instruction queue sitting between fetch and issue. Accepts one
//   instruction per cycle and releases one per cycle through valid/ready
//   handshakes; both may happen in the same cycle. The head entry is shown
//   combinationally on deq_data (first-word fall-through), occupancy is kept
//   in a registered counter, and a synchronous flush empties the queue for
//   branch mispredict recovery.
//
// Parameters:
//   WIDTH      instruction word width in bits (default 16)
//   AW         pointer width, DEPTH = 2**AW entries (default 3 -> 8 entries)
//   AF_THRESH  almost_full threshold in entries, 1..DEPTH (default 6); only
//              present when INSTR_QUEUE_ALMOST_FULL_EN is defined
//
// Optional feature macro:
//   INSTR_QUEUE_ALMOST_FULL_EN  adds the AF_THRESH parameter and the
//                               almost_full output. Undefined by default.
//
// Ports:
//   CLK          in   clock, rising edge
//   CLR          in   asynchronous reset, active-high
//   flush        in   synchronous discard of all entries
//   enq_valid    in   producer offers enq_data
//   enq_ready    out  queue can accept (= ~full)
//   enq_data     in   instruction to store
//   deq_valid    out  head entry valid (= ~empty)
//   deq_ready    in   consumer takes the head this cycle
//   deq_data     out  head instruction, combinational from storage; 0 when empty
//   count        out  occupancy 0..DEPTH
//   full         out  count == DEPTH
//   empty        out  count == 0
//   ovf_err      out  sticky: enq_valid seen while full (cleared by CLR only)
//   almost_full  out  count >= AF_THRESH (optional)
//
// Handshake semantics (both sides):
//   A transfer fires on a rising CLK edge where valid & ready are both 1.
//   The producer keeps enq_data stable while enq_valid=1 and not yet fired;
//   the queue keeps deq_data stable while deq_valid=1 and deq_ready=0.
//   enq_ready and deq_valid depend only on registered state, so there is no
//   combinational path from either ready input to either ready/valid output.
// ---------------------------------------------------------------------------
module instr_queue_param #(
  parameter int WIDTH     = 16,
  parameter int AW        = 3
`ifdef INSTR_QUEUE_ALMOST_FULL_EN
  ,
  parameter int AF_THRESH = 6
`endif
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic             flush,
  input  logic             enq_valid,
  output logic             enq_ready,
  input  logic [WIDTH-1:0] enq_data,
  output logic             deq_valid,
  input  logic             deq_ready,
  output logic [WIDTH-1:0] deq_data,
  output logic [AW:0]      count,
  output logic             full,
  output logic             empty,
  output logic             ovf_err
`ifdef INSTR_QUEUE_ALMOST_FULL_EN
  ,
  output logic             almost_full
`endif
);

  localparam int          DEPTH   = 1 << AW;
  localparam logic [AW:0] C_DEPTH = (AW+1)'(DEPTH);
  localparam logic [AW:0] C_ONE   = (AW+1)'(1);

  // Storage is deliberately not reset; validity comes from r_count.
  logic [WIDTH-1:0] r_mem [DEPTH];

  logic [AW-1:0] r_head;
  logic [AW-1:0] r_tail;
  logic [AW:0]   r_count;
  logic          r_full;
  logic          r_empty;
  logic          r_ovf_err;

  logic          w_enq_fire;
  logic          w_deq_fire;
  logic [AW:0]   w_count_nxt;

  // Ready/valid come from registered flags only, so a full queue refuses a
  // write even when the consumer is draining in the same cycle.
  assign w_enq_fire = enq_valid & ~r_full;
  assign w_deq_fire = deq_ready & ~r_empty;

  // Next occupancy. Flush wins over any same-cycle transfer.
  always_comb begin
    w_count_nxt = r_count;
    if (flush) begin
      w_count_nxt = '0;
    end else begin
      case ({w_enq_fire, w_deq_fire})
        2'b10:   w_count_nxt = r_count + C_ONE;
        2'b01:   w_count_nxt = r_count - C_ONE;
        default: w_count_nxt = r_count;
      endcase
    end
  end

  // Control state: pointers, counter and the flags derived from the
  // next-state count, so full/empty are plain flops on the outputs.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
      r_full  <= 1'b0;
      r_empty <= 1'b1;
    end else begin
      if (flush) begin
        r_head <= '0;
        r_tail <= '0;
      end else begin
        // AW-bit pointers wrap DEPTH-1 -> 0 by overflow.
        if (w_enq_fire) r_tail <= r_tail + 1'b1;
        if (w_deq_fire) r_head <= r_head + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == C_DEPTH);
      r_empty <= (w_count_nxt == '0);
    end
  end

  // Overflow flag is sticky across flush; only CLR clears it.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_ovf_err <= 1'b0;
    end else if (enq_valid && r_full) begin
      r_ovf_err <= 1'b1;
    end
  end

  // Storage write. A flushed cycle discards the offered word.
  always_ff @(posedge CLK) begin
    if (w_enq_fire && !flush) begin
      r_mem[r_tail] <= enq_data;
    end
  end

`ifdef INSTR_QUEUE_ALMOST_FULL_EN
  localparam logic [AW:0] C_AF_THRESH = (AW+1)'(AF_THRESH);

  logic r_almost_full;

  // Registered alongside count from the same next-state value, so it tracks
  // count exactly and drops to 0 on flush.
  always_ff @(posedge CLK or posedge CLR) begin
    if (CLR) begin
      r_almost_full <= 1'b0;
    end else begin
      r_almost_full <= (w_count_nxt >= C_AF_THRESH);
    end
  end

  assign almost_full = r_almost_full;
`endif

  assign enq_ready = ~r_full;
  assign deq_valid = ~r_empty;
  assign count     = r_count;
  assign full      = r_full;
  assign empty     = r_empty;
  assign ovf_err   = r_ovf_err;

  // No bypass: a word written at edge N appears here after edge N, and an
  // empty queue always presents zero.
  assign deq_data  = r_empty ? '0 : r_mem[r_head];

endmodule
